// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants, FSM states and flag positions for the FPU datapath
package fpu_pkg;
    localparam int BIAS = 127;
    localparam int EMIN = -126;
    localparam int EMAX = 127;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, SPECIAL, MUL, ROUND, DONE} state_t;

    localparam int FLAG_INV = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;
endpackage

// File: rtl/rec_round_pack.sv
// rec_round_pack: normalize, denormalize, round-to-nearest-even and pack a 48-bit product
module rec_round_pack
    import fpu_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] e,
    input  logic [47:0]       p,
    output logic [31:0]       fp,
    output logic [3:0]        flags
);
    logic signed [11:0] e1, d, eo;
    logic [23:0] m, mr;
    logic g, s, gr, sr, tiny, inc, ovf, inx;
    logic [4:0] sh;
    logic [50:0] v;
    logic [24:0] r;

    // Select the top 24 bits, shift tiny results into the subnormal range, round and pack
    always_comb begin
        e1 = {{2{e[9]}}, e} + {11'd0, p[47]};
        m = p[47] ? p[47:24] : p[46:23];
        g = p[47] ? p[23] : p[22];
        s = p[47] ? |p[22:0] : |p[21:0];
        tiny = e1 < 12'(EMIN);
        d = 12'(EMIN) - e1;
        sh = !tiny ? 5'd0 : d > 12'sd26 ? 5'd26 : d[4:0];
        v = {m, g, 26'd0} >> sh;
        mr = v[50:27];
        gr = v[26];
        sr = s | |v[25:0];
        inc = gr & (sr | mr[0]);
        r = {1'b0, mr} + {24'd0, inc};
        eo = e1 + {11'd0, r[24]};
        ovf = !tiny && eo > 12'(EMAX);
        inx = gr | sr;
        fp = ovf ? {sign, 8'hFF, 23'd0}
           : tiny ? {sign, 7'd0, r[23], r[22:0]}
           : {sign, 8'(eo + 12'(BIAS)), r[24] ? 23'd0 : r[22:0]};
        flags = '0;
        flags[FLAG_OVF] = ovf;
        flags[FLAG_UNF] = tiny & inx;
        flags[FLAG_INX] = inx | ovf;
    end
endmodule

// File: rtl/recfn_mul_seq.sv
// recfn_mul_seq: sequential shift-add binary32 multiplier on recoded operands
module recfn_mul_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W = 9,
    parameter int SIG_W = 32,
    parameter int MAN_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [EXP_W-1:0] b_exp,
    input  logic [SIG_W-1:0] a_sig,
    input  logic [SIG_W-1:0] b_sig,
    input  logic             a_isNAN,
    input  logic             a_isINf,
    input  logic             a_isZero,
    input  logic             b_isNAN,
    input  logic             b_isINf,
    input  logic             b_isZero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_fp,
    output logic [3:0]       out_flags
);
    state_t state, next;
    logic sign, sp_inv, s_in, inval, nan, inf, special;
    logic signed [EXP_W:0] e;
    logic [MAN_W-1:0] mcand, mplr;
    logic [2*MAN_W-1:0] acc;
    logic [MAN_W:0] sum;
    logic [4:0] cnt;
    logic [31:0] sp_fp, sp_next, rp_fp;
    logic [3:0] rp_fl;
    logic unused;

    assign unused = ^{a_sig[SIG_W-1:MAN_W], b_sig[SIG_W-1:MAN_W]};
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;

    // Classify the incoming pair and form the next partial-product sum
    always_comb begin
        s_in = a_sign ^ b_sign;
        inval = (a_isINf & b_isZero) | (a_isZero & b_isINf);
        nan = a_isNAN | b_isNAN | inval;
        inf = a_isINf | b_isINf;
        special = nan | inf | a_isZero | b_isZero;
        sp_next = nan ? CANON_NAN : inf ? {s_in, 8'hFF, 23'd0} : {s_in, 31'd0};
        sum = {1'b0, acc[2*MAN_W-1:MAN_W]} + {1'b0, mplr[0] ? mcand : {MAN_W{1'b0}}};
    end

    // State register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next;

    // Next-state logic
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (in_valid) next = special ? SPECIAL : MUL;
            SPECIAL: next = DONE;
            MUL:     if (cnt == 5'(MAN_W - 1)) next = ROUND;
            ROUND:   next = DONE;
            DONE:    if (out_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Operand capture, shift-add iteration and result registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sign <= 1'b0;
            e <= '0;
            mcand <= '0;
            mplr <= '0;
            acc <= '0;
            cnt <= '0;
            sp_fp <= '0;
            sp_inv <= 1'b0;
            out_fp <= '0;
            out_flags <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign <= s_in;
                    e <= {a_exp[EXP_W-1], a_exp} + {b_exp[EXP_W-1], b_exp};
                    mcand <= a_sig[MAN_W-1:0];
                    mplr <= b_sig[MAN_W-1:0];
                    acc <= '0;
                    cnt <= '0;
                    sp_fp <= sp_next;
                    sp_inv <= inval;
                end
                SPECIAL: begin
                    out_fp <= sp_fp;
                    out_flags <= {sp_inv, 3'd0};
                end
                MUL: begin
                    acc <= {sum, acc[MAN_W-1:1]};
                    mplr <= mplr >> 1;
                    cnt <= cnt + 5'd1;
                end
                ROUND: begin
                    out_fp <= rp_fp;
                    out_flags <= rp_fl;
                end
                default: ;
            endcase
        end

    rec_round_pack u_rp (
        .sign(sign),
        .e(e),
        .p(acc),
        .fp(rp_fp),
        .flags(rp_fl)
    );
endmodule

// File: tb/tb_recfn_mul_seq.sv
// tb_recfn_mul_seq: directed and random checks of recfn_mul_seq against an exact-arithmetic model
module tb_recfn_mul_seq;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic a_sign, b_sign, a_isNAN, a_isINf, a_isZero, b_isNAN, b_isINf, b_isZero;
    logic [8:0] a_exp, b_exp;
    logic [31:0] a_sig, b_sig, out_fp;
    logic [3:0] out_flags;
    int checks = 0, failures = 0;

    localparam logic [31:0] DA [8] = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'hFF000000,
                                      32'h00800000, 32'h00000001, 32'h7F800000, 32'h7FC00000};
    localparam logic [31:0] DB [8] = '{32'h40000000, 32'h3F800001, 32'h7F000000, 32'h7F000000,
                                      32'h3F000000, 32'h3E800000, 32'h00000000, 32'h3F800000};
    localparam logic [31:0] DR [8] = '{32'h40400000, 32'h3F800002, 32'h7F800000, 32'hFF800000,
                                      32'h00400000, 32'h00000000, 32'h7FC00000, 32'h7FC00000};
    localparam logic [3:0] DF [8] = '{4'h0, 4'h1, 4'h5, 4'h5, 4'h0, 4'h3, 4'h8, 4'h0};

    recfn_mul_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
        .a_sig(a_sig), .b_sig(b_sig),
        .a_isNAN(a_isNAN), .a_isINf(a_isINf), .a_isZero(a_isZero),
        .b_isNAN(b_isNAN), .b_isINf(b_isINf), .b_isZero(b_isZero),
        .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_spec(input logic [31:0] x);
        return x[30:23] == 8'hFF || x[30:0] == 31'd0;
    endfunction

    // IEEE binary32 -> {sign, exp9, sig32, isNAN, isINf, isZero}
    function automatic logic [44:0] rec(input logic [31:0] x);
        logic [31:0] m;
        int ex;
        m = 0;
        ex = 0;
        if (x[30:23] == 8'hFF) return {x[31], 9'd0, 32'd0, x[22:0] != 0, x[22:0] == 0, 1'b0};
        if (x[30:0] == 0) return {x[31], 9'd0, 32'd0, 3'b001};
        if (x[30:23] == 0) begin
            m = {9'd0, x[22:0]};
            ex = -126;
            for (int i = 0; i < 23; i++) if (!m[23]) begin m = m << 1; ex--; end
        end else begin
            m = {8'd0, 1'b1, x[22:0]};
            ex = int'(x[30:23]) - 127;
        end
        return {x[31], 9'(ex), m, 3'b000};
    endfunction

    // Exact product P*2^base rounded to the binary32 grid with an integer remainder test
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f);
        logic s, an, bn, ai, bi, az, bz, inx, up;
        longint unsigned ma, mb, p, rem, half;
        longint fl, mag;
        int ea, eb, base, msb, e, k, sh;
        s = a[31] ^ b[31];
        an = a[30:23] == 8'hFF && a[22:0] != 0;
        bn = b[30:23] == 8'hFF && b[22:0] != 0;
        ai = a[30:23] == 8'hFF && a[22:0] == 0;
        bi = b[30:23] == 8'hFF && b[22:0] == 0;
        az = a[30:0] == 0;
        bz = b[30:0] == 0;
        f = 0;
        r = 0;
        if (an || bn || (ai && bz) || (az && bi)) begin
            r = 32'h7FC00000;
            f[3] = (ai && bz) || (az && bi);
            return;
        end
        if (ai || bi) begin r = {s, 8'hFF, 23'd0}; return; end
        if (az || bz) begin r = {s, 31'd0}; return; end
        ma = a[30:23] == 0 ? longint'(a[22:0]) : longint'({1'b1, a[22:0]});
        mb = b[30:23] == 0 ? longint'(b[22:0]) : longint'({1'b1, b[22:0]});
        ea = a[30:23] == 0 ? -149 : int'(a[30:23]) - 150;
        eb = b[30:23] == 0 ? -149 : int'(b[30:23]) - 150;
        p = ma * mb;
        base = ea + eb;
        msb = 0;
        for (int i = 0; i < 48; i++) if (p[i]) msb = i;
        e = base + msb;
        k = (e - 23 > -149) ? e - 23 : -149;
        sh = k - base;
        if (sh == 0) begin
            fl = longint'(p); inx = 0; up = 0;
        end else if (sh >= 62) begin
            fl = 0; inx = 1; up = 0;
        end else begin
            fl = longint'(p >> sh);
            rem = p & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            inx = rem != 0;
            up = rem > half || (rem == half && fl[0]);
        end
        fl = fl + longint'(up);
        mag = (e < -126) ? fl : (longint'(e) + 127) * 8388608 + fl - 8388608;
        if (mag >= 64'sh7F800000) begin
            r = {s, 8'hFF, 23'd0};
            f = 4'b0101;
        end else begin
            r = {s, mag[30:0]};
            f[0] = inx;
            f[1] = (e < -126) && inx;
        end
    endfunction

    function automatic logic [31:0] gen_fp();
        int c;
        logic [22:0] fr;
        c = $urandom_range(0, 15);
        fr = 23'($urandom);
        case (c)
            0: return {1'($urandom), 31'd0};
            1: return {1'($urandom), 8'hFF, 23'd0};
            2: return {1'($urandom), 8'hFF, fr | 23'd1};
            3, 4: return {1'($urandom), 8'd0, ($urandom_range(0, 1) != 0) ? (fr | 23'd1) : 23'($urandom_range(1, 40))};
            default: return {1'($urandom), 8'($urandom_range(1, 254)), fr};
        endcase
    endfunction

    task automatic scramble();
        {a_sign, a_exp, a_sig, a_isNAN, a_isINf, a_isZero} = 45'({$urandom, $urandom});
        {b_sign, b_exp, b_sig, b_isNAN, b_isINf, b_isZero} = 45'({$urandom, $urandom});
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ef,
                          input logic [3:0] efl, input int hold);
        int lat;
        lat = 0;
        while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        check("in_ready_idle", in_ready, 1);
        {a_sign, a_exp, a_sig, a_isNAN, a_isINf, a_isZero} = rec(a);
        {b_sign, b_exp, b_sig, b_isNAN, b_isINf, b_isZero} = rec(b);
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        scramble();
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check($sformatf("latency %h*%h", a, b), lat, is_spec(a) || is_spec(b) ? 2 : 26);
        check($sformatf("out_fp %h*%h", a, b), out_fp, ef);
        check($sformatf("out_flags %h*%h", a, b), out_flags, efl);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold", {out_valid, in_ready, out_flags, out_fp}, {1'b1, 1'b0, efl, ef});
        end
        out_ready = 1;
        in_valid = 1;
        @(posedge clk); #1;
        out_ready = 0;
        in_valid = 0;
        check("release", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        check("no_capture_in_done", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [31:0] a, b, r;
        logic [3:0] f;
        int bad;
        scramble();
        #1;
        check("reset_outputs", {out_valid, in_ready, out_flags, out_fp}, {1'b0, 1'b1, 36'd0});
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 8; i++) run_op(DA[i], DB[i], DR[i], DF[i], i == 0 ? 10 : 1);

        {a_sign, a_exp, a_sig, a_isNAN, a_isINf, a_isZero} = rec(32'h3FC00000);
        {b_sign, b_exp, b_sig, b_isNAN, b_isINf, b_isZero} = rec(32'h40000000);
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("reset_mid_mul", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        rst = 0;
        out_ready = 1;
        bad = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) bad = 1; end
        out_ready = 0;
        check("no_stray_result", bad, 0);

        for (int n = 0; n < 200; n++) begin
            a = gen_fp();
            b = gen_fp();
            model(a, b, r, f);
            run_op(a, b, r, f, $urandom_range(0, 2));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
